bin_sched: RTL and testbench

BIN_SCHED -- requirements
Module: bin_sched

---
 rtl/bin_sched_pkg.sv | 24 ++
 rtl/bin_sched_if.sv | 41 ++++
 rtl/bin_sched_step.sv | 24 ++
 rtl/bin_sched.sv | 171 +++++++++++++++++
 tb/tb_bin_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bin_sched_pkg.sv
// Shared types and defaults for the bin scheduler: FSM states, the command record and the
// numbins clamp used when a command is loaded.
package bin_sched_pkg;

  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned MAX_BINS_DEF = 127;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHold
  } state_e;

  typedef struct packed {
    logic [7:0] pstate;
    logic       bypass;
    logic [6:0] numbins;
  } cmd_t;

  function automatic logic [6:0] clamp_bins(input logic [6:0] n, input int unsigned max_bins);
    return (32'(n) > max_bins) ? 7'(max_bins) : n;
  endfunction

endpackage

// File: rtl/bin_sched_if.sv
// Command, decoder and output-beat signals of the bin scheduler.
// master = the scheduler itself, slave = the surrounding command source / decoder / sink.
interface bin_sched_if
  import bin_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_pstate;
  logic             cmd_bypass;
  logic [6:0]       cmd_numbins;

  logic             dec_en;
  logic             dec_bypass;
  logic [7:0]       dec_pstate;
  logic [1:0]       dec_n_bin;
  logic [WIDTH-1:0] dec_bin;

  logic             bin_valid;
  logic             bin_ready;
  logic [WIDTH-1:0] bin_data;
  logic [2:0]       bin_cnt;
  logic             bin_last;

  logic             busy;

  modport master (
    input  cmd_valid, cmd_pstate, cmd_bypass, cmd_numbins, dec_bin, bin_ready,
    output cmd_ready, dec_en, dec_bypass, dec_pstate, dec_n_bin,
           bin_valid, bin_data, bin_cnt, bin_last, busy
  );

  modport slave (
    output cmd_valid, cmd_pstate, cmd_bypass, cmd_numbins, dec_bin, bin_ready,
    input  cmd_ready, dec_en, dec_bypass, dec_pstate, dec_n_bin,
           bin_valid, bin_data, bin_cnt, bin_last, busy
  );

endinterface

// File: rtl/bin_sched_step.sv
// Combinational step-size calculator: one bin per step for regular bins, up to WIDTH for bypass.
module bin_sched_step
  import bin_sched_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic       bypass_i,
  input  logic [6:0] rem_i,
  output logic [2:0] step_o,
  output logic [1:0] n_bin_o
);

  always_comb begin
    if (!bypass_i) begin
      step_o = 3'd1;
    end else if (rem_i < 7'(WIDTH)) begin
      step_o = rem_i[2:0];
    end else begin
      step_o = 3'(WIDTH);
    end
    n_bin_o = 2'(step_o - 3'd1);
  end

endmodule

// File: rtl/bin_sched.sv
// Bin scheduler: splits a command into decoder steps and registers decoded bins into beats.
// Optional BIN_SCHED_PREFETCH_EN adds a one-entry command buffer so commands chain without a gap.
module bin_sched
  import bin_sched_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned MAX_BINS = MAX_BINS_DEF
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  bin_sched_if.master  bus_io
);

  state_e           state_q, state_d;
  logic [7:0]       pstate_q, pstate_d;
  logic             bypass_q, bypass_d;
  logic [6:0]       rem_q, rem_d;
  logic             bin_valid_q, bin_valid_d;
  logic [WIDTH-1:0] bin_data_q, bin_data_d;
  logic [2:0]       bin_cnt_q, bin_cnt_d;
  logic             bin_last_q, bin_last_d;

  logic [2:0]       step;
  logic [1:0]       n_bin;
  logic             dec_en, last_step, cmd_hs, load_ok, src_v;
  logic [WIDTH-1:0] mask;
  logic [6:0]       src_bins;
  cmd_t             cmd_in, src;

`ifdef BIN_SCHED_PREFETCH_EN
  cmd_t             buf_q, buf_d;
  logic             buf_valid_q, buf_valid_d;
`endif

  bin_sched_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .bypass_i (bypass_q),
    .rem_i    (rem_q),
    .step_o   (step),
    .n_bin_o  (n_bin)
  );

  assign cmd_in = '{pstate: bus_io.cmd_pstate, bypass: bus_io.cmd_bypass,
                    numbins: bus_io.cmd_numbins};

`ifdef BIN_SCHED_PREFETCH_EN
  assign bus_io.cmd_ready = reset_ni && !buf_valid_q;
`else
  assign bus_io.cmd_ready = reset_ni && (state_q == StIdle);
`endif

  assign cmd_hs    = bus_io.cmd_valid && bus_io.cmd_ready;
  // Never issue a step into an output register that cannot drain this cycle.
  assign dec_en    = (state_q == StRun) && (!bin_valid_q || bus_io.bin_ready);
  assign last_step = dec_en && (rem_q == 7'(step));

  always_comb begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      mask[i] = (3'(i) < step);
    end
  end

  always_comb begin
    state_d     = state_q;
    pstate_d    = pstate_q;
    bypass_d    = bypass_q;
    rem_d       = rem_q;
    bin_valid_d = bin_valid_q;
    bin_data_d  = bin_data_q;
    bin_cnt_d   = bin_cnt_q;
    bin_last_d  = bin_last_q;
    load_ok     = 1'b0;
`ifdef BIN_SCHED_PREFETCH_EN
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    src         = buf_valid_q ? buf_q : cmd_in;
    src_v       = buf_valid_q || cmd_hs;
`else
    src         = cmd_in;
    src_v       = cmd_hs;
`endif
    src_bins    = clamp_bins(src.numbins, MAX_BINS);

    case (state_q)
      StIdle: load_ok = 1'b1;
      StRun: begin
        if (dec_en) begin
          rem_d = rem_q - 7'(step);
          if (last_step) begin
            state_d = StIdle;
            load_ok = 1'b1;
          end
        end else begin
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus_io.bin_ready) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase

    // A new command is taken either from idle or straight after the final step.
    if (load_ok && src_v) begin
      pstate_d = src.pstate;
      bypass_d = src.bypass;
      rem_d    = src_bins;
      state_d  = (src_bins != 7'd0) ? StRun : StIdle;
    end

`ifdef BIN_SCHED_PREFETCH_EN
    if (load_ok && buf_valid_q) begin
      buf_valid_d = 1'b0;
    end else if (cmd_hs && !load_ok) begin
      buf_d       = cmd_in;
      buf_valid_d = 1'b1;
    end
`endif

    if (dec_en) begin
      bin_valid_d = 1'b1;
      bin_data_d  = bus_io.dec_bin & mask;
      bin_cnt_d   = step;
      bin_last_d  = last_step;
    end else if (bus_io.bin_ready) begin
      bin_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      pstate_q    <= '0;
      bypass_q    <= 1'b0;
      rem_q       <= '0;
      bin_valid_q <= 1'b0;
      bin_data_q  <= '0;
      bin_cnt_q   <= '0;
      bin_last_q  <= 1'b0;
`ifdef BIN_SCHED_PREFETCH_EN
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pstate_q    <= pstate_d;
      bypass_q    <= bypass_d;
      rem_q       <= rem_d;
      bin_valid_q <= bin_valid_d;
      bin_data_q  <= bin_data_d;
      bin_cnt_q   <= bin_cnt_d;
      bin_last_q  <= bin_last_d;
`ifdef BIN_SCHED_PREFETCH_EN
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
`endif
    end
  end

  assign bus_io.dec_en     = dec_en;
  assign bus_io.dec_bypass = bypass_q;
  assign bus_io.dec_pstate = pstate_q;
  assign bus_io.dec_n_bin  = (state_q == StRun) ? n_bin : 2'd0;
  assign bus_io.bin_valid  = bin_valid_q;
  assign bus_io.bin_data   = bin_data_q;
  assign bus_io.bin_cnt    = bin_cnt_q;
  assign bus_io.bin_last   = bin_last_q;
  assign bus_io.busy       = (state_q != StIdle) || bin_valid_q;

endmodule

// File: tb/tb_bin_sched.sv
// Self-checking bench for bin_sched: directed scenarios plus randomized commands, checked
// against a per-command model that precomputes the step list and expected beats.
module tb_bin_sched;
  import bin_sched_pkg::*;

  localparam int unsigned W      = 4;
  localparam int unsigned MAXB   = 100;
  localparam int          BUDGET = 2000;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  bin_sched_if #(.WIDTH(W)) bus ();

  bin_sched #(
    .WIDTH    (W),
    .MAX_BINS (MAXB)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus_io   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic report_timeout(input string tag);
    n_chk++;
    $error("FAIL %s: observed no completion expected completion within budget", tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"},  bus.cmd_ready, 0);
    chk({tag, "_dec_en"},     bus.dec_en, 0);
    chk({tag, "_bin_valid"},  bus.bin_valid, 0);
    chk({tag, "_bin_data"},   bus.bin_data, 0);
    chk({tag, "_bin_cnt"},    bus.bin_cnt, 0);
    chk({tag, "_bin_last"},   bus.bin_last, 0);
    chk({tag, "_dec_n_bin"},  bus.dec_n_bin, 0);
    chk({tag, "_dec_bypass"}, bus.dec_bypass, 0);
    chk({tag, "_dec_pstate"}, bus.dec_pstate, 0);
    chk({tag, "_busy"},       bus.busy, 0);
  endtask

  // mode: 0 = sink always ready, 1 = random ready, 2 = ready low for 5 cycles after first beat
  task automatic run_cmd(input logic byp, input logic [7:0] ps, input logic [6:0] nb,
                         input int mode);
    int         steps[$];
    logic [3:0] q_data[$];
    logic [2:0] q_cnt[$];
    logic       q_last[$];
    int         rem, s, total, issued, consumed, cyc, stall_left;
    logic       accepted, stall_started, prev_dec, prev_hold, prev_last;
    logic [3:0] prev_data, m;
    logic [2:0] prev_cnt;
    logic [7:0] m8;

    rem = (int'(nb) > int'(MAXB)) ? int'(MAXB) : int'(nb);
    while (rem > 0) begin
      s = byp ? ((rem < int'(W)) ? rem : int'(W)) : 1;
      steps.push_back(s);
      rem -= s;
    end
    total = steps.size();
    issued = 0; consumed = 0; cyc = 0; stall_left = 0;
    accepted = 1'b0; stall_started = 1'b0; prev_dec = 1'b0; prev_hold = 1'b0;
    prev_last = 1'b0; prev_data = '0; prev_cnt = '0;

    forever begin
      @(negedge clk);
      bus.cmd_valid   = !accepted;
      bus.cmd_bypass  = byp;
      bus.cmd_pstate  = ps;
      bus.cmd_numbins = nb;
      if (mode == 2 && bus.bin_valid && !stall_started) begin
        stall_started = 1'b1;
        stall_left    = 5;
      end
      if (mode == 1) begin
        bus.bin_ready = ($urandom_range(0, 3) != 0);
      end else if (stall_left > 0) begin
        bus.bin_ready = 1'b0;
        stall_left--;
      end else begin
        bus.bin_ready = 1'b1;
      end
      bus.dec_bin = 4'($urandom);
      #1;
      if (accepted && issued == total && consumed == total && !bus.bin_valid) begin
        chk("busy_end", bus.busy, 0);
        chk("ready_end", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b0;
        return;
      end
      if (cyc == BUDGET) begin
        report_timeout("run_cmd");
        bus.cmd_valid = 1'b0;
        return;
      end
      cyc++;

      if (prev_dec) chk("beat_latency", bus.bin_valid, 1);
      if (prev_hold) begin
        chk("hold_valid", bus.bin_valid, 1);
        chk("hold_data", bus.bin_data, prev_data);
        chk("hold_cnt", bus.bin_cnt, prev_cnt);
        chk("hold_last", bus.bin_last, prev_last);
      end
      if (bus.bin_valid && !bus.bin_ready) chk("no_step_when_full", bus.dec_en, 0);
`ifndef BIN_SCHED_PREFETCH_EN
      if (accepted && issued < total) chk("ready_low_busy", bus.cmd_ready, 0);
`endif

      if (bus.bin_valid && bus.bin_ready) begin
        if (q_data.size() == 0) begin
          chk("extra_beat", bus.bin_valid, 0);
        end else begin
          chk("bin_data", bus.bin_data, q_data.pop_front());
          chk("bin_cnt", bus.bin_cnt, q_cnt.pop_front());
          chk("bin_last", bus.bin_last, q_last.pop_front());
          consumed++;
        end
      end

      if (bus.dec_en) begin
        if (issued >= total) begin
          chk("extra_dec_en", bus.dec_en, 0);
        end else begin
          s = steps[issued];
          chk("dec_n_bin", bus.dec_n_bin, s - 1);
          chk("dec_bypass", bus.dec_bypass, byp);
          chk("dec_pstate", bus.dec_pstate, ps);
          m8 = (8'd1 << s) - 8'd1;
          m  = m8[3:0];
          q_data.push_back(bus.dec_bin & m);
          q_cnt.push_back(3'(s));
          q_last.push_back(issued == total - 1);
          issued++;
        end
      end

      if (bus.cmd_valid && bus.cmd_ready) accepted = 1'b1;
      prev_dec  = bus.dec_en;
      prev_hold = bus.bin_valid && !bus.bin_ready;
      prev_data = bus.bin_data;
      prev_cnt  = bus.bin_cnt;
      prev_last = bus.bin_last;
    end
  endtask

  initial begin
    int         hs, ndec, cyc, first_dec, gap;
    logic       rb;
    logic [7:0] rps;
    logic [6:0] rnb;

    reset_n         = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_pstate  = '0;
    bus.cmd_bypass  = 1'b0;
    bus.cmd_numbins = '0;
    bus.dec_bin     = '0;
    bus.bin_ready   = 1'b1;
    #3;
    chk_reset("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_por", bus.cmd_ready, 1);

    run_cmd(1'b0, 8'h2A, 7'd3, 0);
    run_cmd(1'b1, 8'h05, 7'd10, 0);
    run_cmd(1'b1, 8'h3C, 7'd8, 2);
    run_cmd(1'b0, 8'h01, 7'd0, 0);
    run_cmd(1'b0, 8'h02, 7'd1, 0);
    run_cmd(1'b1, 8'h11, 7'd120, 1);
    run_cmd(1'b0, 8'h12, 7'd101, 0);
    run_cmd(1'b1, 8'h13, 7'd100, 2);

    // Reset asserted while the second step of a 12-bin bypass command is on the decoder.
    hs = 0; ndec = 0; cyc = 0;
    bus.cmd_bypass  = 1'b1;
    bus.cmd_pstate  = 8'h77;
    bus.cmd_numbins = 7'd12;
    bus.bin_ready   = 1'b1;
    while (ndec < 2 && cyc < 50) begin
      @(negedge clk);
      bus.cmd_valid = (hs == 0);
      bus.dec_bin   = 4'($urandom);
      #1;
      if (bus.cmd_valid && bus.cmd_ready) hs = 1;
      if (bus.dec_en) ndec++;
      cyc++;
    end
    if (ndec < 2) report_timeout("rst_mid_wait");
    #1;
    reset_n = 1'b0;
    #1;
    chk_reset("mid");
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("ready_after_mid_rst", bus.cmd_ready, 1);
    run_cmd(1'b1, 8'h55, 7'd7, 0);

`ifdef BIN_SCHED_PREFETCH_EN
    hs = 0; cyc = 0; first_dec = -1; gap = -1;
    bus.cmd_bypass  = 1'b1;
    bus.cmd_pstate  = 8'h21;
    bus.cmd_numbins = 7'd4;
    bus.bin_ready   = 1'b1;
    while (cyc < 20) begin
      @(negedge clk);
      bus.cmd_valid = (hs < 2);
      bus.dec_bin   = 4'($urandom);
      #1;
      if (bus.dec_en) begin
        if (first_dec < 0) first_dec = cyc;
        else if (gap < 0) gap = cyc - first_dec;
      end
      if (bus.cmd_valid && bus.cmd_ready) hs++;
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    chk("prefetch_dec_gap", gap, 1);
`endif

    for (int i = 0; i < 25; i++) begin
      rb  = 1'($urandom_range(0, 1));
      rps = 8'($urandom);
      rnb = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 12));
      run_cmd(rb, rps, rnb, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
